// File: rtl/z80_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : z80_arb_pkg
//  Purpose  : Shared types and helpers for the Z80 system-bus arbiter.
//             - arb_state_t : arbiter FSM state encoding
//             - MSEL_W      : width of the sysmux master-select bus
//                             (CPU plus NUM_DMA masters)
//  Revision : 1.0  initial release
// ============================================================================
package z80_arb_pkg;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        REQ_BUS = 2'd1,
        DMA_OWN = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Bits needed to encode 0 (CPU) through num_dma (last DMA master).
    function automatic int MSEL_W(input int num_dma);
        return (num_dma < 1) ? 1 : $clog2(num_dma + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/z80_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : z80_rr_pick
//  Purpose  : Combinational round-robin selector. Returns the first
//             requesting index at or after i_rr_ptr+1, wrapping modulo
//             NUM_DMA.
//  Ports    : i_req     [NUM_DMA]  request vector
//             i_rr_ptr  [IDX_W]    index of the previous winner
//             o_winner  [IDX_W]    selected index (0 when none valid)
//             o_valid   [1]        at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module z80_rr_pick
    import z80_arb_pkg::*;
#(
    parameter int NUM_DMA = 2,
    parameter int IDX_W   = MSEL_W(NUM_DMA)
) (
    input  logic [NUM_DMA-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    int w_dist;
    int w_best;

    // Each requester is ranked by its distance from the slot following the
    // previous winner; the smallest distance wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_best   = NUM_DMA;
        w_dist   = 0;
        for (int j = 0; j < NUM_DMA; j++) begin
            w_dist = (j - int'(i_rr_ptr) - 1 + 2 * NUM_DMA) % NUM_DMA;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_winner = IDX_W'(j);
                o_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : z80_bus_arbiter
//  Purpose  : Shares the Z80 (tv80n) system bus between the CPU and NUM_DMA
//             DMA masters using BUSRQ/BUSAK. The CPU always regains the bus
//             between DMA tenures; DMA masters are served round-robin and a
//             tenure is capped at MAX_HOLD cycles.
//  Ports    : clk           system clock, rising edge
//             rst           synchronous active-high reset
//             dma_req       per-DMA level request
//             dma_gnt       per-DMA grant, one-hot or zero (registered)
//             cpu_busrq_n   BUSRQ to the CPU, active-low (registered)
//             cpu_busak_n   BUSAK from the CPU, active-low
//             msel          sysmux select, 0 = CPU, k = DMA k-1 (registered)
//             hold_timeout  one-cycle pulse when MAX_HOLD revokes a tenure
//  Revision : 1.0  initial release
// ============================================================================
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int NUM_DMA  = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_DMA-1:0]           dma_req,
    output logic [NUM_DMA-1:0]           dma_gnt,
    output logic                         cpu_busrq_n,
    input  logic                         cpu_busak_n,
    output logic [MSEL_W(NUM_DMA)-1:0]   msel,
    output logic                         hold_timeout
);

    localparam int c_idx_w = MSEL_W(NUM_DMA);
    localparam int c_cnt_w = $clog2(MAX_HOLD + 1);

    arb_state_t           r_state;
    logic                 r_busrq_n;
    logic [NUM_DMA-1:0]   r_gnt;
    logic [c_idx_w-1:0]   r_msel;
    logic                 r_timeout;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_rr_ptr;

    logic [c_idx_w-1:0]   w_winner;
    logic                 w_valid;
    logic [NUM_DMA-1:0]   w_onehot;
    logic                 w_req_held;

    z80_rr_pick #(
        .NUM_DMA (NUM_DMA),
        .IDX_W   (c_idx_w)
    ) u_pick (
        .i_req    (dma_req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_onehot = '0;
        for (int j = 0; j < NUM_DMA; j++) begin
            w_onehot[j] = (w_winner == c_idx_w'(j));
        end
    end

    // The current grant is one-hot, so masking the requests with it yields
    // the owner's request without needing a separate owner index.
    assign w_req_held = |(dma_req & r_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CPU_OWN;
            r_busrq_n <= 1'b1;
            r_gnt     <= '0;
            r_msel    <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_rr_ptr  <= c_idx_w'(NUM_DMA - 1);
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                CPU_OWN: begin
                    if (|dma_req) begin
                        r_state   <= REQ_BUS;
                        r_busrq_n <= 1'b0;
                    end
                end
                REQ_BUS: begin
                    // A request withdrawn before BUSAK aborts the cycle.
                    if (!w_valid) begin
                        r_state   <= RELEASE;
                        r_busrq_n <= 1'b1;
                    end else if (!cpu_busak_n) begin
                        r_gnt    <= w_onehot;
                        r_msel   <= w_winner + c_idx_w'(1);
                        r_rr_ptr <= w_winner;
                        r_cnt    <= c_cnt_w'(1);
                        r_state  <= DMA_OWN;
                    end
                end
                DMA_OWN: begin
                    if (!w_req_held || (r_cnt == c_cnt_w'(MAX_HOLD))) begin
                        r_gnt     <= '0;
                        r_msel    <= '0;
                        r_busrq_n <= 1'b1;
                        r_cnt     <= '0;
                        // Still requesting here means the cap ended it;
                        // the pulse coincides with the grant dropping.
                        r_timeout <= w_req_held;
                        r_state   <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                RELEASE: begin
                    if (cpu_busak_n) begin
                        r_state <= CPU_OWN;
                    end
                end
                default: r_state <= CPU_OWN;
            endcase
        end
    end

    assign dma_gnt      = r_gnt;
    assign cpu_busrq_n  = r_busrq_n;
    assign msel         = r_msel;
    assign hold_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z80_bus_arbiter
//  Purpose  : Directed self-checking bench for z80_bus_arbiter with
//             NUM_DMA=2, MAX_HOLD=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_z80_bus_arbiter;

    localparam int NUM_DMA  = 2;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   dma_req = 2'b00;
    logic [1:0]   dma_gnt;
    logic         cpu_busrq_n;
    logic         cpu_busak_n = 1'b1;
    logic [1:0]   msel;
    logic         hold_timeout;

    int n_asserts = 0;
    int n_fail    = 0;

    // Round-robin run with CPU acknowledging one cycle after BUSRQ,
    // edges 1..16 after the requests go high.
    logic [1:0] exp_gnt   [16] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [1:0] exp_msel  [16] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0,
                                   2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       exp_busrq [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_to    [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    z80_bus_arbiter #(
        .NUM_DMA  (NUM_DMA),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dma_req      (dma_req),
        .dma_gnt      (dma_gnt),
        .cpu_busrq_n  (cpu_busrq_n),
        .cpu_busak_n  (cpu_busak_n),
        .msel         (msel),
        .hold_timeout (hold_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic [1:0] m,
                             input logic rq, input logic to);
        check({tag, ".gnt"},     {30'd0, dma_gnt},      {30'd0, g});
        check({tag, ".msel"},    {30'd0, msel},         {30'd0, m});
        check({tag, ".busrq_n"}, {31'd0, cpu_busrq_n},  {31'd0, rq});
        check({tag, ".timeout"}, {31'd0, hold_timeout}, {31'd0, to});
    endtask

    initial begin
        // ---- reset state ----
        tick(); tick();
        check_all("reset", 2'b00, 2'd0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        check_all("idle", 2'b00, 2'd0, 1'b1, 1'b0);

        // ---- single DMA0 request, BUSAK two cycles after BUSRQ ----
        dma_req = 2'b01;
        tick();                                            // -> REQ_BUS
        check_all("a_busrq", 2'b00, 2'd0, 1'b0, 1'b0);
        tick();                                            // busak still high
        check_all("a_wait", 2'b00, 2'd0, 1'b0, 1'b0);
        cpu_busak_n = 1'b0;
        tick();                                            // grant
        check_all("a_grant", 2'b01, 2'd1, 1'b0, 1'b0);
        tick();
        check_all("a_hold", 2'b01, 2'd1, 1'b0, 1'b0);
        dma_req = 2'b00;
        tick();                                            // request dropped -> RELEASE
        check_all("a_end", 2'b00, 2'd0, 1'b1, 1'b0);
        cpu_busak_n = 1'b1;
        tick();                                            // -> CPU_OWN
        check_all("a_cpu", 2'b00, 2'd0, 1'b1, 1'b0);

        // ---- request withdrawn before BUSAK ----
        dma_req = 2'b01;
        tick();
        check_all("c_busrq", 2'b00, 2'd0, 1'b0, 1'b0);
        dma_req = 2'b00;
        tick();                                            // -> RELEASE
        check_all("c_abort", 2'b00, 2'd0, 1'b1, 1'b0);
        tick();                                            // -> CPU_OWN
        check_all("c_cpu", 2'b00, 2'd0, 1'b1, 1'b0);
        dma_req = 2'b10;                                   // CPU_OWN reacts again
        tick();
        check_all("c_rereq", 2'b00, 2'd0, 1'b0, 1'b0);
        dma_req = 2'b00;
        tick();
        tick();
        check_all("c_idle", 2'b00, 2'd0, 1'b1, 1'b0);

        // ---- round robin with both requesting, MAX_HOLD cap ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dma_req = 2'b11;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_all($sformatf("b_e%0d", i + 1), exp_gnt[i], exp_msel[i],
                      exp_busrq[i], exp_to[i]);
            if (dma_gnt != 2'b00)
                check($sformatf("b_gnt_busak_e%0d", i + 1), {31'd0, cpu_busak_n}, 32'd0);
            cpu_busak_n = cpu_busrq_n;
        end

        // ---- reset during a DMA0 tenure, BUSAK still low ----
        rst = 1'b1;
        cpu_busak_n = 1'b0;
        tick();
        check_all("d_rst", 2'b00, 2'd0, 1'b1, 1'b0);
        rst = 1'b0;
        cpu_busak_n = cpu_busrq_n;
        dma_req = 2'b11;
        tick();
        check_all("d_busrq", 2'b00, 2'd0, 1'b0, 1'b0);
        cpu_busak_n = cpu_busrq_n;
        tick();
        check_all("d_first", 2'b01, 2'd1, 1'b0, 1'b0);
        dma_req = 2'b00;
        tick();
        check_all("d_end", 2'b00, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter: NUM_DMA, default 2, number of DMA bus masters sharing the system bus with the CPU (1..7).
REQ-002 Parameter: MAX_HOLD, default 64, maximum clk cycles one DMA tenure may last (2..1024).
REQ-003 Port: clk  in  1  system clock (masterclk domain); one clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: dma_req  in  NUM_DMA  per-DMA bus request, level, held until done.
REQ-006 Port: dma_gnt  out  NUM_DMA  per-DMA grant, registered, one-hot or zero.
REQ-007 Port: cpu_busrq_n  out  1  to tv80n busrq_n, registered, active-low.
REQ-008 Port: cpu_busak_n  in  1  from tv80n busak_n, active-low.
REQ-009 Port: msel  out  $clog2(NUM_DMA+1)  sysmux master select; 0 = CPU, k = DMA k-1; registered.
REQ-010 Port: hold_timeout  out  1  one-cycle pulse when a tenure is revoked by MAX_HOLD.

Function
REQ-011 The FSM SHALL have states CPU_OWN, REQ_BUS, DMA_OWN, RELEASE.
REQ-012 CPU_OWN: busrq_n=1, msel=0, dma_gnt=0; any dma_req bit high -> REQ_BUS, busrq_n=0 from the next edge.
REQ-013 REQ_BUS: busrq_n held 0; if all dma_req low before busak_n=0 -> RELEASE.
REQ-014 REQ_BUS with busak_n=0 sampled: winner = first requesting index at or after rr_ptr+1 (mod NUM_DMA); next edge sets dma_gnt[winner]=1, msel=winner+1, rr_ptr=winner, hold counter=1 -> DMA_OWN.
REQ-015 dma_gnt and msel SHALL change on the same edge; grant never asserted while cpu_busak_n=1.
REQ-016 DMA_OWN: counter increments each cycle; tenure ends when dma_req[winner]=0 or counter=MAX_HOLD.
REQ-017 Tenure end by counter=MAX_HOLD with dma_req[winner] still high: hold_timeout=1 for exactly that cycle.
REQ-018 Tenure end: next edge dma_gnt=0, msel=0, busrq_n=1 -> RELEASE (CPU always regains bus between DMA tenures; no DMA-to-DMA handoff).
REQ-019 RELEASE: busrq_n=1; stay until busak_n=1 sampled -> CPU_OWN; CPU_OWN SHALL last at least 1 cycle before re-requesting.
REQ-020 Grant latency: dma_req rise in CPU_OWN -> busrq_n low after 1 edge; dma_gnt high 1 edge after busak_n=0 sampled.
REQ-021 Simultaneous requests: round-robin per REQ-014; after reset DMA0 wins first (rr_ptr resets to NUM_DMA-1).
REQ-022 dma_req of non-winners SHALL be ignored during DMA_OWN; dma_req changes in RELEASE SHALL not affect the state.
REQ-023 Counter width $clog2(MAX_HOLD+1); SHALL never wrap.

Reset
REQ-024 On rst=1 at an edge: state=CPU_OWN, busrq_n=1, dma_gnt=0, msel=0, hold_timeout=0, counter=0, rr_ptr=NUM_DMA-1.
REQ-025 rst asserted mid-tenure SHALL drop dma_gnt and return msel=0 on that same edge, regardless of busak_n.

Structure
REQ-026 Shared package z80_arb_pkg SHALL hold the state enum arb_state_t and MSEL_W constant function.
REQ-027 One sub-module, z80_rr_pick: combinational round-robin pick (req, rr_ptr -> winner index, valid).
REQ-028 All outputs driven straight from flops; no combinational path from input to output.

Verification
REQ-029 DMA0 req=1, CPU asserts busak_n=0 two cycles after busrq_n falls -> dma_gnt=01, msel=1 one edge after busak_n sampled low.
REQ-030 dma_req=11 held continuously, busak_n follows busrq_n with 1-cycle delay -> grants alternate DMA0, DMA1, DMA0, each separated by RELEASE/CPU_OWN.
REQ-031 MAX_HOLD=4, DMA1 req held -> gnt high 4 cycles, hold_timeout pulses once, gnt=0, msel=0, busrq_n=1.
REQ-032 dma_req pulses high 1 cycle then drops before busak_n=0 -> no grant issued, busrq_n returns to 1, FSM back to CPU_OWN.
REQ-033 rst=1 during DMA_OWN -> next edge dma_gnt=0, msel=0, busrq_n=1; after release, first grant goes to DMA0.
